// File: rtl/banked_dual_ram_pkg.sv
// Shared defaults and helpers for the banked dual-port RAM.
package banked_dual_ram_pkg;

    localparam int unsigned DEF_TAG_W      = 2;
    localparam int unsigned DEF_ADDR_WIDTH = 10;
    localparam int unsigned DEF_DATA_WIDTH = 32;

    // Number of banks selected by a tag of the given width.
    function automatic int unsigned bank_count(input int unsigned tag_w);
        return 32'd1 << tag_w;
    endfunction

endpackage

// File: rtl/banked_dual_ram_bank_ram_dp.sv
// One bank: true dual-port RAM, independent read and write channel per port,
// read-first, 1-cycle registered read, port A wins a same-address write clash.
module bank_ram_dp #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  wr_en_a_i,
    input  logic [ADDR_WIDTH-1:0] wr_addr_a_i,
    input  logic [DATA_WIDTH-1:0] wr_data_a_i,
    input  logic                  rd_en_a_i,
    input  logic [ADDR_WIDTH-1:0] rd_addr_a_i,
    output logic [DATA_WIDTH-1:0] rd_data_a_o,
    input  logic                  wr_en_b_i,
    input  logic [ADDR_WIDTH-1:0] wr_addr_b_i,
    input  logic [DATA_WIDTH-1:0] wr_data_b_i,
    input  logic                  rd_en_b_i,
    input  logic [ADDR_WIDTH-1:0] rd_addr_b_i,
    output logic [DATA_WIDTH-1:0] rd_data_b_o
);

    localparam int unsigned DEPTH = 32'd1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] rd_data_a_q;
    logic [DATA_WIDTH-1:0] rd_data_b_q;

    // Reads sample old contents; B's write is issued before A's so A overrides on a clash.
    always_ff @(posedge clk) begin
        if (rd_en_a_i) rd_data_a_q <= mem_q[rd_addr_a_i];
        if (rd_en_b_i) rd_data_b_q <= mem_q[rd_addr_b_i];
        if (wr_en_b_i) mem_q[wr_addr_b_i] <= wr_data_b_i;
        if (wr_en_a_i) mem_q[wr_addr_a_i] <= wr_data_a_i;
    end

    assign rd_data_a_o = rd_data_a_q;
    assign rd_data_b_o = rd_data_b_q;

endmodule

// File: rtl/banked_dual_ram.sv
// Two-port word RAM split into 2^TAG_W banks selected by the upper address bits.
// Each port has its own read and write channel; reads have 1-cycle latency and hold.
module banked_dual_ram
    import banked_dual_ram_pkg::*;
#(
    parameter int unsigned TAG_W      = DEF_TAG_W,
    parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] s_write_addr_a,
    input  logic                  s_write_req_a,
    input  logic [DATA_WIDTH-1:0] s_write_data_a,
    input  logic [ADDR_WIDTH-1:0] s_read_addr_a,
    input  logic                  s_read_req_a,
    output logic [DATA_WIDTH-1:0] s_read_data_a,
    input  logic [ADDR_WIDTH-1:0] s_write_addr_b,
    input  logic                  s_write_req_b,
    input  logic [DATA_WIDTH-1:0] s_write_data_b,
    input  logic [ADDR_WIDTH-1:0] s_read_addr_b,
    input  logic                  s_read_req_b,
    output logic [DATA_WIDTH-1:0] s_read_data_b
);

    localparam int unsigned BANK_ADDR_W = ADDR_WIDTH - TAG_W;
    localparam int unsigned NUM_BANKS   = bank_count(TAG_W);

    logic [TAG_W-1:0]       wr_tag_a, rd_tag_a, wr_tag_b, rd_tag_b;
    logic [BANK_ADDR_W-1:0] wr_row_a, rd_row_a, wr_row_b, rd_row_b;

    logic [NUM_BANKS-1:0]   we_a, re_a, we_b, re_b;
    logic [DATA_WIDTH-1:0]  bank_rdata_a [NUM_BANKS];
    logic [DATA_WIDTH-1:0]  bank_rdata_b [NUM_BANKS];

    // Registered tag steers the output mux; valid masks the bank registers,
    // which carry no reset, so the outputs read 0 until the first post-reset read.
    logic [TAG_W-1:0]       rd_tag_a_q, rd_tag_a_d;
    logic [TAG_W-1:0]       rd_tag_b_q, rd_tag_b_d;
    logic                   rd_vld_a_q, rd_vld_a_d;
    logic                   rd_vld_b_q, rd_vld_b_d;

    assign wr_tag_a = s_write_addr_a[ADDR_WIDTH-1 -: TAG_W];
    assign rd_tag_a = s_read_addr_a[ADDR_WIDTH-1 -: TAG_W];
    assign wr_tag_b = s_write_addr_b[ADDR_WIDTH-1 -: TAG_W];
    assign rd_tag_b = s_read_addr_b[ADDR_WIDTH-1 -: TAG_W];
    assign wr_row_a = s_write_addr_a[BANK_ADDR_W-1:0];
    assign rd_row_a = s_read_addr_a[BANK_ADDR_W-1:0];
    assign wr_row_b = s_write_addr_b[BANK_ADDR_W-1:0];
    assign rd_row_b = s_read_addr_b[BANK_ADDR_W-1:0];

    // Bank decode: only the addressed bank is enabled; requests during reset are dropped.
    always_comb begin
        we_a = '0;
        re_a = '0;
        we_b = '0;
        re_b = '0;
        for (int unsigned i = 0; i < NUM_BANKS; i++) begin
            we_a[i] = s_write_req_a && !reset && (wr_tag_a == TAG_W'(i));
            re_a[i] = s_read_req_a  && !reset && (rd_tag_a == TAG_W'(i));
            we_b[i] = s_write_req_b && !reset && (wr_tag_b == TAG_W'(i));
            re_b[i] = s_read_req_b  && !reset && (rd_tag_b == TAG_W'(i));
        end
    end

    for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
        bank_ram_dp #(
            .ADDR_WIDTH(BANK_ADDR_W),
            .DATA_WIDTH(DATA_WIDTH)
        ) u_bank (
            .clk         (clk),
            .wr_en_a_i   (we_a[g]),
            .wr_addr_a_i (wr_row_a),
            .wr_data_a_i (s_write_data_a),
            .rd_en_a_i   (re_a[g]),
            .rd_addr_a_i (rd_row_a),
            .rd_data_a_o (bank_rdata_a[g]),
            .wr_en_b_i   (we_b[g]),
            .wr_addr_b_i (wr_row_b),
            .wr_data_b_i (s_write_data_b),
            .rd_en_b_i   (re_b[g]),
            .rd_addr_b_i (rd_row_b),
            .rd_data_b_o (bank_rdata_b[g])
        );
    end

    // Next read tag/valid: captured only when a read is requested, otherwise held.
    always_comb begin
        rd_tag_a_d = rd_tag_a_q;
        rd_vld_a_d = rd_vld_a_q;
        rd_tag_b_d = rd_tag_b_q;
        rd_vld_b_d = rd_vld_b_q;
        if (s_read_req_a) begin
            rd_tag_a_d = rd_tag_a;
            rd_vld_a_d = 1'b1;
        end
        if (s_read_req_b) begin
            rd_tag_b_d = rd_tag_b;
            rd_vld_b_d = 1'b1;
        end
    end

    // Read tag/valid registers with asynchronous clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_tag_a_q <= '0;
            rd_vld_a_q <= 1'b0;
            rd_tag_b_q <= '0;
            rd_vld_b_q <= 1'b0;
        end else begin
            rd_tag_a_q <= rd_tag_a_d;
            rd_vld_a_q <= rd_vld_a_d;
            rd_tag_b_q <= rd_tag_b_d;
            rd_vld_b_q <= rd_vld_b_d;
        end
    end

    // Output mux per port, forced to 0 until a read has completed since reset.
    always_comb begin
        s_read_data_a = rd_vld_a_q ? bank_rdata_a[rd_tag_a_q] : '0;
        s_read_data_b = rd_vld_b_q ? bank_rdata_b[rd_tag_b_q] : '0;
    end

endmodule

// File: tb/tb_banked_dual_ram.sv
// Directed bench for banked_dual_ram with a word-level reference model.
module tb_banked_dual_ram;

    localparam int unsigned AW = 10;
    localparam int unsigned DW = 32;
    localparam int unsigned DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [AW-1:0] wa_a = '0, ra_a = '0, wa_b = '0, ra_b = '0;
    logic          wr_a = 1'b0, rr_a = 1'b0, wr_b = 1'b0, rr_b = 1'b0;
    logic [DW-1:0] wd_a = '0, wd_b = '0;
    logic [DW-1:0] rd_a, rd_b;

    int checks = 0;
    int errors = 0;

    banked_dual_ram #(
        .TAG_W(2),
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .s_write_addr_a (wa_a),
        .s_write_req_a  (wr_a),
        .s_write_data_a (wd_a),
        .s_read_addr_a  (ra_a),
        .s_read_req_a   (rr_a),
        .s_read_data_a  (rd_a),
        .s_write_addr_b (wa_b),
        .s_write_req_b  (wr_b),
        .s_write_data_b (wd_b),
        .s_read_addr_b  (ra_b),
        .s_read_req_b   (rr_b),
        .s_read_data_b  (rd_b)
    );

    always #5 clk = ~clk;

    // Reference model: a flat word array with a written flag per word.
    logic [DW-1:0] mdl_mem [DEPTH];
    bit            mdl_wr  [DEPTH];
    logic [DW-1:0] exp_a = '0, exp_b = '0;
    bit            known_a = 1'b0, known_b = 1'b0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            exp_a = '0; known_a = 1'b1;
            exp_b = '0; known_b = 1'b1;
        end else begin
            // Reads see the memory as it was before this edge's writes.
            if (rr_a) begin exp_a = mdl_mem[ra_a]; known_a = mdl_wr[ra_a]; end
            if (rr_b) begin exp_b = mdl_mem[ra_b]; known_b = mdl_wr[ra_b]; end
            if (wr_b) begin mdl_mem[wa_b] = wd_b; mdl_wr[wa_b] = 1'b1; end
            if (wr_a) begin mdl_mem[wa_a] = wd_a; mdl_wr[wa_a] = 1'b1; end
        end
    end

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
        end
    endtask

    // Continuous comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (known_a) check("model_a", rd_a, exp_a);
        if (known_b) check("model_b", rd_b, exp_b);
    end

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic idle;
        wr_a = 1'b0; rr_a = 1'b0; wr_b = 1'b0; rr_b = 1'b0;
    endtask

    task automatic write_a(input logic [AW-1:0] a, input logic [DW-1:0] d);
        wa_a = a; wd_a = d; wr_a = 1'b1;
    endtask

    task automatic write_b(input logic [AW-1:0] a, input logic [DW-1:0] d);
        wa_b = a; wd_b = d; wr_b = 1'b1;
    endtask

    task automatic read_a(input logic [AW-1:0] a);
        ra_a = a; rr_a = 1'b1;
    endtask

    task automatic read_b(input logic [AW-1:0] a);
        ra_b = a; rr_b = 1'b1;
    endtask

    initial begin
        // Reset asserted mid-cycle: outputs must clear without a clock edge.
        #1 reset = 1'b1;
        #1;
        check("reset_a_async", rd_a, 32'h0);
        check("reset_b_async", rd_b, 32'h0);
        tick; tick;
        #1 reset = 1'b0;
        tick;
        check("post_reset_a", rd_a, 32'h0);
        check("post_reset_b", rd_b, 32'h0);

        // Port A stores, port B reads back on consecutive cycles.
        write_a(10'h000, 32'hDEADBEEF); tick;
        write_a(10'h3FF, 32'h12345678); tick;
        idle; read_b(10'h3FF); tick;
        check("b_rd_3ff", rd_b, 32'h12345678);
        read_b(10'h000); tick;
        check("b_rd_000", rd_b, 32'hDEADBEEF);
        idle; tick;
        check("b_hold", rd_b, 32'hDEADBEEF);

        // Parallel writes into different banks, then crossed reads.
        write_a(10'h105, 32'hA5A5A5A5); write_b(10'h205, 32'h5A5A5A5A); tick;
        idle; read_a(10'h205); read_b(10'h105); tick;
        check("bank_a_rd_205", rd_a, 32'h5A5A5A5A);
        check("bank_b_rd_105", rd_b, 32'hA5A5A5A5);

        // Read-first across ports.
        idle; write_a(10'h040, 32'h11111111); tick;
        idle; write_a(10'h040, 32'h22222222); read_b(10'h040); tick;
        check("rf_cross_old", rd_b, 32'h11111111);
        idle; read_b(10'h040); tick;
        check("rf_cross_new", rd_b, 32'h22222222);

        // Read-first on the same port.
        idle; write_a(10'h041, 32'h33333333); tick;
        idle; write_a(10'h041, 32'h44444444); read_a(10'h041); tick;
        check("rf_same_old", rd_a, 32'h33333333);
        idle; read_a(10'h041); tick;
        check("rf_same_new", rd_a, 32'h44444444);

        // Same-address write collision: port A wins; output holds while idle.
        idle; write_a(10'h0C0, 32'hAAAA0000); write_b(10'h0C0, 32'hBBBB0000); tick;
        idle; read_a(10'h0C0); read_b(10'h0C0); tick;
        check("coll_a", rd_a, 32'hAAAA0000);
        check("coll_b", rd_b, 32'hAAAA0000);
        idle;
        for (int i = 0; i < 5; i++) begin
            tick;
            check("hold_a", rd_a, 32'hAAAA0000);
            check("hold_b", rd_b, 32'hBBBB0000 ^ 32'h11110000);
        end

        // Reset mid-operation: contents retained, requests during reset ignored.
        write_a(10'h321, 32'hCAFEF00D); tick;
        idle; #1 reset = 1'b1;
        #1;
        check("mid_reset_a", rd_a, 32'h0);
        check("mid_reset_b", rd_b, 32'h0);
        write_a(10'h321, 32'hDEADDEAD); read_a(10'h0C0); read_b(10'h0C0);
        tick; tick;
        check("in_reset_a", rd_a, 32'h0);
        check("in_reset_b", rd_b, 32'h0);
        idle; #1 reset = 1'b0;
        tick;
        check("after_reset_a", rd_a, 32'h0);
        read_a(10'h321); read_b(10'h321); tick;
        check("retain_a", rd_a, 32'hCAFEF00D);
        check("retain_b", rd_b, 32'hCAFEF00D);

        // Mixed traffic on a small address set spanning all banks, checked by the model.
        idle;
        for (int i = 0; i < 300; i++) begin
            logic [AW-1:0] a0, a1, a2, a3;
            a0 = {$urandom_range(3, 0), 8'($urandom_range(3, 0))};
            a1 = {$urandom_range(3, 0), 8'($urandom_range(3, 0))};
            a2 = {$urandom_range(3, 0), 8'($urandom_range(3, 0))};
            a3 = {$urandom_range(3, 0), 8'($urandom_range(3, 0))};
            wa_a = a0; wd_a = $urandom; wr_a = 1'($urandom_range(1, 0));
            wa_b = a1; wd_b = $urandom; wr_b = 1'($urandom_range(1, 0));
            ra_a = a2; rr_a = 1'($urandom_range(1, 0));
            ra_b = a3; rr_b = 1'($urandom_range(1, 0));
            tick;
        end
        idle;
        tick; tick;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/banked_dual_ram.md
Name: banked_dual_ram

Overview:
- Two-port, word-addressed on-chip RAM built from 2^TAG_W independent banks; the upper TAG_W address bits select the bank.
- Port A serves the memory/DMA side (load/store of tiles); port B serves the compute array side. Each port has its own independent read and write channel.
- One instance is used per array lane inside the output/input buffers, so depth and width are set per instance.

Parameters:
TAG_W, 2, log2 of bank count; upper TAG_W bits of every address are the bank tag; must be >= 1 and < ADDR_WIDTH
ADDR_WIDTH, 10, total word-address width; total depth = 2^ADDR_WIDTH words
DATA_WIDTH, 32, word width in bits
BANK_ADDR_W (derived), ADDR_WIDTH-TAG_W, per-bank address width; each bank holds 2^BANK_ADDR_W words

Ports:
clk  in  1  single clock; all state updates on rising edge
reset  in  1  asynchronous, active-high reset
s_write_addr_a  in  ADDR_WIDTH  port A write word address; [ADDR_WIDTH-1 -: TAG_W] = bank, low bits = bank row
s_write_req_a  in  1  port A write strobe
s_write_data_a  in  DATA_WIDTH  port A write data
s_read_addr_a  in  ADDR_WIDTH  port A read address
s_read_req_a  in  1  port A read strobe
s_read_data_a  out  DATA_WIDTH  port A read data, valid 1 cycle after s_read_req_a
s_write_addr_b  in  ADDR_WIDTH  port B write address
s_write_req_b  in  1  port B write strobe
s_write_data_b  in  DATA_WIDTH  port B write data
s_read_addr_b  in  ADDR_WIDTH  port B read address
s_read_req_b  in  1  port B read strobe
s_read_data_b  out  DATA_WIDTH  port B read data, valid 1 cycle after s_read_req_b

Behaviour:
- Writes: on a rising edge with s_write_req_x=1, mem[addr] <= data. Takes effect at that edge; no handshake, no backpressure, every request accepted.
- Reads: a request at edge N latches the word at addr; the data appears on s_read_data_x after edge N and holds until the next read request on that port.
- Latency is exactly 1 cycle. Back-to-back requests every cycle are supported.
- No read request: s_read_data_x holds its last value; it must not change or go X.
- Bank selection:
  - Tag = addr[ADDR_WIDTH-1 -: TAG_W]; row = addr[BANK_ADDR_W-1:0].
  - Only the addressed bank is enabled for that port.
  - The per-port tag is registered on read request and drives the output mux.
- Both ports may access any bank, including the same bank, in the same cycle. Up to 2 reads and 2 writes proceed in parallel every cycle.
- Read-during-write to the same address in the same cycle (same or opposite port): read returns the OLD contents (read-first). The new data is visible to reads issued from the next cycle on.
- Simultaneous writes from A and B to the same address: port A's data is stored. Different addresses: both stored.
- Reset (asynchronous assert, synchronous-safe release):
  - s_read_data_a, s_read_data_b and both registered read tags go to 0 immediately.
  - Memory contents are NOT cleared; they are retained through reset.
  - A request presented while reset is high is ignored (no write, no read update).
- Reads of never-written locations return undefined data (X in simulation); the bench must not check them.
- Address wrap does not occur: every address within 2^ADDR_WIDTH is a valid, distinct word.

Decomposition:
- No shared package is needed; all widths derive from the three parameters. BANK_ADDR_W is a localparam.
- One natural sub-module: bank_ram_dp.
  - Parameters: ADDR_WIDTH=BANK_ADDR_W, DATA_WIDTH.
  - Behaviour: true dual-port, read-first, 1-cycle registered read, port A write priority.
  - Instantiation: generated 2^TAG_W times.
- The top level contains bank decode, the registered tags, output muxes and the output reset logic.

Test Plan:
- Reset with defaults (TAG_W=2, ADDR_WIDTH=10, DATA_WIDTH=32) -> both s_read_data outputs = 0 while reset is high, without waiting for a clock edge.
- Port A writes 0xDEADBEEF @0x000 and 0x12345678 @0x3FF; port B reads 0x3FF then 0x000 on consecutive cycles -> s_read_data_b = 0x12345678 then 0xDEADBEEF, each 1 cycle after its request.
- Bank parallelism: in the same cycle A writes 0xA5A5A5A5 @0x105 (bank 1) and B writes 0x5A5A5A5A @0x205 (bank 2); next cycle A reads 0x205, B reads 0x105 -> A = 0x5A5A5A5A, B = 0xA5A5A5A5.
- Read-first: @0x040 holds 0x11111111; same cycle A writes 0x22222222 @0x040 and B reads 0x040 -> B = 0x11111111; B re-reads next cycle -> 0x22222222.
- Write collision: A writes 0xAAAA0000, B writes 0xBBBB0000, both @0x0C0 in the same cycle -> later read returns 0xAAAA0000. Hold s_read_req low 5 cycles -> output unchanged.
- Reset mid-operation: write 0xCAFEF00D @0x321, assert reset, then deassert -> outputs 0 during reset; read of 0x321 after reset returns 0xCAFEF00D.
